// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

    // Default bus widths.
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Completion record returned to the command side.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one requester and its downstream slave.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    // Requester side: drives address/control/data, observes the slave reply.
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA
    );

    // Slave side: the mirror image.
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: single-beat commands in, SETUP/ACCESS sequencing out,
// one-cycle response pulse back, with an optional ACCESS wait timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    apb_master_if.master      bus
);

    // The counter must be able to reach TIMEOUT_CYC-1 without wrapping.
    if (TIMEOUT_CYC >= (2 ** CNT_W)) begin : g_cnt_too_narrow
        $error("apb_master: TIMEOUT_CYC does not fit in CNT_W bits");
    end

    localparam bit              TO_EN     = (TIMEOUT_CYC != 0);
    localparam int              TO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];

    apb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // The counter holds the number of PREADY-low ACCESS cycles already seen,
    // so the current cycle is the last one allowed when it reads TIMEOUT_CYC-1.
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    // Transfer FSM with all bus and response outputs registered.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the pre-edge values; blocking would create
    // order-dependent, simulation-only behaviour.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= 1'b0;
            bus.PADDR   <= '0;
            bus.PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            // The response is a pulse; it is re-armed only on completion.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Address, data and direction stay frozen until the
                        // next accepted command.
                        bus.PWRITE  <= cmd_write;
                        bus.PADDR   <= cmd_addr;
                        bus.PWDATA  <= cmd_wdata;
                        bus.PSEL    <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        cmd_ready   <= 1'b0;
                        state       <= SETUP;
                    end else begin
                        // Ready rises one edge after reset release and stays
                        // high for as long as we idle.
                        cmd_ready <= 1'b1;
                    end
                end

                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    if (bus.PREADY) begin
                        // A ready slave wins over a timeout on the same edge.
                        bus.PSEL    <= 1'b0;
                        bus.PENABLE <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        bus.PSEL    <= 1'b0;
                        bus.PENABLE <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    bus.PSEL    <= 1'b0;
                    bus.PENABLE <= 1'b0;
                    cmd_ready   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction model + per-cycle compare,
// plus directed scenarios with hand-computed expectations.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- downstream slave ----------------
    int          slv_waits = 0;
    bit          slv_hang  = 0;
    int          acc_cnt   = 0;
    logic [63:0] sdata     = '0;

    assign bus.PREADY = slv_hang ? 1'b0 : (acc_cnt >= slv_waits);
    assign bus.PRDATA = (bus.PSEL && bus.PENABLE) ? bus.PADDR : 32'hdead_beef;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
            sdata <= {bus.PADDR, bus.PWDATA};
    end

    // ---------------- transaction-level model ----------------
    bit          m_live = 0;
    bit          m_busy;
    int          m_k;
    int          m_waits;
    bit          e_ready;
    bit          e_rv;
    apb_rsp_t    e_rsp;
    bit          e_write;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;

    task automatic model_step();
        if (PRESET) begin
            m_live = 1; m_busy = 0; m_k = 0; m_waits = 0;
            e_ready = 0; e_rv = 0; e_rsp = '0;
            e_write = 0; e_addr = '0; e_wdata = '0;
        end else begin
            e_rv = 0;
            if (!m_busy) begin
                if (cmd_valid && e_ready) begin
                    m_busy = 1; m_k = 1; m_waits = 0; e_ready = 0;
                    e_write = cmd_write; e_addr = cmd_addr; e_wdata = cmd_wdata;
                end else begin
                    e_ready = 1;
                end
            end else if (m_k == 1) begin
                m_k = 2;
            end else if (bus.PREADY) begin
                m_busy = 0; e_ready = 1; e_rv = 1;
                e_rsp.err = 0; e_rsp.rdata = e_write ? 32'h0 : bus.PRDATA;
            end else begin
                m_waits++;
                if (TO != 0 && m_waits == TO) begin
                    m_busy = 0; e_ready = 1; e_rv = 1;
                    e_rsp.err = 1; e_rsp.rdata = 32'h0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge PCLK);
        model_step();
    end

    // Compare every cycle, mid-period.
    always @(negedge PCLK) begin
        if (m_live) begin
            check("ctrl", {cmd_ready, bus.PSEL, bus.PENABLE, rsp_valid},
                  {e_ready, m_busy, m_busy && (m_k >= 2), e_rv});
            check("rsp", {rsp_rdata, rsp_err}, e_rsp);
            check("bus", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {e_write, e_addr, e_wdata});
        end
    end

    // Response log for ordering checks.
    logic [32:0] rq[$];
    always @(negedge PCLK) if (rsp_valid === 1'b1) rq.push_back({rsp_err, rsp_rdata});

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int hs_cyc);
        bit   got;
        logic rdy;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            rdy = cmd_ready;
            @(posedge PCLK); #1;
            if (rdy === 1'b1) got = 1;
        end
        check("handshake", got, 1'b1);
        hs_cyc = cyc;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
    endtask

    task automatic run_until_rsp(output int acc);
        bit seen;
        acc = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge PCLK); #1;
            if (bus.PENABLE) acc++;
            if (rsp_valid) seen = 1;
        end
        check("rsp_wait", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int          hs, prev_hs, acc, nb;
        logic [31:0] a, d;
        logic [32:0] exp_q[$];
        logic [31:0] rd_addr[3];
        rd_addr[0] = 32'h0000_0100; rd_addr[1] = 32'h0000_0204; rd_addr[2] = 32'h0000_03fc;

        // Reset with a command pending.
        PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 32'h1111_2222; cmd_wdata = 32'h3333_4444;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_outs", {bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid}, 4'b0000);
        check("rst_paddr", bus.PADDR, 32'h0);
        PRESET = 1'b0; cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        check("rst_ready", cmd_ready, 1'b1);

        // Zero-wait write.
        slv_waits = 0;
        send(1'b1, 32'h0000_1234, 32'h0000_abcd, 0, hs);
        check("w_setup", {bus.PSEL, bus.PENABLE}, 2'b10);
        @(posedge PCLK); #1;
        check("w_access", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
              {3'b111, 32'h0000_1234, 32'h0000_abcd});
        @(posedge PCLK); #1;
        check("w_rsp", {rsp_valid, rsp_err, cmd_ready, bus.PSEL}, 4'b1010);
        check("w_sdata", sdata, 64'h0000_1234_0000_abcd);

        // Read with three wait states.
        slv_waits = 3;
        send(1'b0, 32'h0000_0042, 32'h5a5a_5a5a, 0, hs);
        run_until_rsp(acc);
        check("r_access_cycles", acc, 4);
        check("r_rsp", {rsp_rdata, rsp_err}, {32'h0000_0042, 1'b0});
        @(posedge PCLK); #1;
        check("r_pulse_once", rsp_valid, 1'b0);
        check("r_hold", rsp_rdata, 32'h0000_0042);

        // Timeout with a stuck slave.
        slv_hang = 1;
        send(1'b0, 32'h0000_0080, 32'h0, 0, hs);
        run_until_rsp(acc);
        check("to_access_cycles", acc, 4);
        check("to_rsp", {bus.PSEL, rsp_valid, rsp_err, rsp_rdata}, {3'b011, 32'h0});
        slv_hang = 0;
        @(posedge PCLK); #1;

        // Back-to-back: 5 writes then 3 reads with cmd_valid held high.
        slv_waits = 0;
        rq.delete();
        prev_hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                a = $urandom; d = $urandom;
                send(1'b1, a, d, 1, hs);
                exp_q.push_back({1'b0, 32'h0});
            end else begin
                a = rd_addr[i-5];
                send(1'b0, a, 32'hffff_ffff, 1, hs);
                exp_q.push_back({1'b0, a});
            end
            if (i > 0) check("b2b_gap", hs - prev_hs, 3);
            prev_hs = hs;
        end
        cmd_valid = 1'b0;
        run_until_rsp(acc);
        @(posedge PCLK); #1;
        check("b2b_count", rq.size(), 8);
        for (int i = 0; i < 8 && i < rq.size(); i++)
            check("b2b_rsp", rq[i], exp_q[i]);

        // Reset in the middle of ACCESS.
        slv_hang = 1;
        send(1'b0, 32'h0000_0099, 32'h0, 0, hs);
        @(posedge PCLK); #1;
        check("ra_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        nb = rq.size();
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check("ra_drop", {bus.PSEL, bus.PENABLE, rsp_valid}, 3'b000);
        PRESET = 1'b0; slv_hang = 0;
        repeat (3) @(posedge PCLK);
        #1;
        check("ra_no_rsp", rq.size(), nb);
        slv_waits = 1;
        send(1'b0, 32'h0000_0055, 32'h0, 0, hs);
        run_until_rsp(acc);
        check("ra_read_cycles", acc, 2);
        check("ra_read", {rsp_rdata, rsp_err}, {32'h0000_0055, 1'b0});

        repeat (2) @(posedge PCLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
